// File: rtl/reg_file_sb.sv
// reg_file_sb: small register file with a per-register pending ("scoreboard") bit.
// Reads are combinational. A write in progress is forwarded to a read of the
// same address in the same cycle. A reserve marks a register pending, and a
// write clears that mark. sb_flush clears every mark. Reset is async active-low.
// Optional feature: define REG_FILE_SB_ZERO_REG_EN to hardwire register 0 to
// zero. Writes to it are dropped, reads of it return 0, and it is never pending.
module reg_file_sb #(
    parameter int DATA_W = 9,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              sb_flush,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd0_busy,
    output logic              rd1_busy,
    output logic              any_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;

    // Next state: apply flush and write-clear first, then the reserve, so the reserve wins.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (sb_flush) begin
            pend_d = '0;
        end
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
            pend_d[wr_addr] = 1'b0;
        end
        if (rsv_en) begin
            pend_d[rsv_addr] = 1'b1;
        end
`ifdef REG_FILE_SB_ZERO_REG_EN
        regs_d[0] = '0;
        pend_d[0] = 1'b0;
`endif
    end

    // State registers: asynchronous clear, then take the next state on every clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // Read port 0: forward the write bypass, force zero for the hardwired register, and force zero during reset.
    always_comb begin
        rd0_data = regs_q[rd0_addr];
        if (wr_en && (wr_addr == rd0_addr)) begin
            rd0_data = wr_data;
        end
`ifdef REG_FILE_SB_ZERO_REG_EN
        if (rd0_addr == '0) begin
            rd0_data = '0;
        end
`endif
        if (!rst_n) begin
            rd0_data = '0;
        end
    end

    // Read port 1: same rules as port 0.
    always_comb begin
        rd1_data = regs_q[rd1_addr];
        if (wr_en && (wr_addr == rd1_addr)) begin
            rd1_data = wr_data;
        end
`ifdef REG_FILE_SB_ZERO_REG_EN
        if (rd1_addr == '0) begin
            rd1_data = '0;
        end
`endif
        if (!rst_n) begin
            rd1_data = '0;
        end
    end

    // Busy flags show only registered pending state; a reserve or clear in the same cycle is not forwarded.
    always_comb begin
        rd0_busy = pend_q[rd0_addr];
        rd1_busy = pend_q[rd1_addr];
        any_busy = |pend_q;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed and randomized checks of reg_file_sb against a
// behavioural array model. Build with REG_FILE_SB_ZERO_REG_EN defined or left
// undefined to match the DUT build.
module tb_reg_file_sb;

    localparam int DW = 9;
    localparam int AW = 2;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr;
    logic          sb_flush;
    logic [AW-1:0] rd0_addr;
    logic [AW-1:0] rd1_addr;
    logic [DW-1:0] rd0_data;
    logic [DW-1:0] rd1_data;
    logic          rd0_busy;
    logic          rd1_busy;
    logic          any_busy;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] mdlData [DEPTH];
    bit            mdlPend [DEPTH];

`ifdef REG_FILE_SB_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    reg_file_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .sb_flush(sb_flush),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd0_data(rd0_data), .rd1_data(rd1_data),
        .rd0_busy(rd0_busy), .rd1_busy(rd1_busy), .any_busy(any_busy)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clear the model to its reset contents.
    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) begin
            mdlData[a] = '0;
            mdlPend[a] = 1'b0;
        end
    endtask

    // Apply one clock edge to the model. Each pending bit is set by a reserve,
    // cleared by a flush or a write, and otherwise keeps its value.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int a = 0; a < DEPTH; a++) begin
            bit hitW = wr_en && (int'(wr_addr) == a);
            bit hitR = rsv_en && (int'(rsv_addr) == a);
            bit hw0  = ZERO_REG && (a == 0);
            if (hitW && !hw0) mdlData[a] = wr_data;
            if (hw0) mdlPend[a] = 1'b0;
            else if (hitR) mdlPend[a] = 1'b1;
            else if (sb_flush || hitW) mdlPend[a] = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
        if (!rst_n) return '0;
        if (ZERO_REG && a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return mdlData[a];
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] a);
        if (!rst_n) return 1'b0;
        return mdlPend[a];
    endfunction

    function automatic logic exp_any();
        logic r = 1'b0;
        if (!rst_n) return 1'b0;
        for (int a = 0; a < DEPTH; a++) r = r | mdlPend[a];
        return r;
    endfunction

    // Advance one clock: the model sees the edge, and new inputs may be driven 1 unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        rsv_en = 0; rsv_addr = 0; sb_flush = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        idle_inputs();
        wr_en = 1; wr_addr = 2; wr_data = 9'h155; rsv_en = 1; rsv_addr = 2; sb_flush = 0;
        rd0_addr = 2; rd1_addr = 1;
        @(posedge clk); #1;
        total++;
        if (rd0_data !== 9'h000) begin bad++; $display("[TB] FAIL reset_rd0 got=%h exp=000", rd0_data); end
        total++;
        if (rd1_data !== 9'h000) begin bad++; $display("[TB] FAIL reset_rd1 got=%h exp=000", rd1_data); end
        total++;
        if ({rd0_busy, rd1_busy, any_busy} !== 3'b000) begin
            bad++; $display("[TB] FAIL reset_busy got=%b exp=000", {rd0_busy, rd1_busy, any_busy});
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
        tick();
        total++;
        if (rd0_data !== 9'h000 || rd0_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_ignored_inputs got=%h/%b exp=000/0", rd0_data, rd0_busy);
        end
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 2; wr_data = 9'h1A5;
        tick();
        idle_inputs();
        rd0_addr = 2; rd1_addr = 3;
        #1;
        total++;
        if (rd0_data !== 9'h1A5) begin bad++; $display("[TB] FAIL write_read_rd0 got=%h exp=1a5", rd0_data); end
        total++;
        if (rd1_data !== 9'h000) begin bad++; $display("[TB] FAIL write_read_rd1 got=%h exp=000", rd1_data); end
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 1; wr_data = 9'h0F0; rd1_addr = 1; rd0_addr = 2;
        @(negedge clk);
        total++;
        if (rd1_data !== 9'h0F0) begin bad++; $display("[TB] FAIL bypass_rd1 got=%h exp=0f0", rd1_data); end
        total++;
        if (rd0_data !== 9'h1A5) begin bad++; $display("[TB] FAIL bypass_other_port got=%h exp=1a5", rd0_data); end
        tick();
        idle_inputs();
        #1;
        total++;
        if (rd1_data !== 9'h0F0) begin bad++; $display("[TB] FAIL bypass_stored got=%h exp=0f0", rd1_data); end
    endtask

    task automatic test_scoreboard();
        rsv_en = 1; rsv_addr = 3; rd0_addr = 3;
        @(negedge clk);
        total++;
        if (rd0_busy !== 1'b0) begin bad++; $display("[TB] FAIL sb_no_bypass got=%b exp=0", rd0_busy); end
        tick();
        idle_inputs();
        #1;
        total++;
        if (rd0_busy !== 1'b1 || any_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL sb_reserve got=%b%b exp=11", rd0_busy, any_busy);
        end
        wr_en = 1; wr_addr = 3; wr_data = 9'h033;
        tick();
        idle_inputs();
        #1;
        total++;
        if (rd0_busy !== 1'b0 || any_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL sb_write_clear got=%b%b exp=00", rd0_busy, any_busy);
        end
        wr_en = 1; wr_addr = 3; wr_data = 9'h0C7; rsv_en = 1; rsv_addr = 3;
        tick();
        idle_inputs();
        #1;
        total++;
        if (rd0_data !== 9'h0C7 || rd0_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL sb_reserve_wins got=%h/%b exp=0c7/1", rd0_data, rd0_busy);
        end
        wr_en = 1; wr_addr = 3; wr_data = 9'h0C7;
        tick();
        idle_inputs();
    endtask

    task automatic test_flush();
        rsv_en = 1; rsv_addr = 1;
        tick();
        rsv_addr = 2;
        tick();
        idle_inputs();
        rd0_addr = 1; rd1_addr = 2;
        #1;
        total++;
        if (rd0_busy !== 1'b1 || rd1_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL flush_pre got=%b%b exp=11", rd0_busy, rd1_busy);
        end
        sb_flush = 1; rsv_en = 1; rsv_addr = 0;
        tick();
        idle_inputs();
        #1;
        total++;
        if (rd0_busy !== 1'b0 || rd1_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL flush_clear got=%b%b exp=00", rd0_busy, rd1_busy);
        end
        total++;
        if (rd0_data !== 9'h0F0 || rd1_data !== 9'h1A5) begin
            bad++; $display("[TB] FAIL flush_data got=%h/%h exp=0f0/1a5", rd0_data, rd1_data);
        end
        rd0_addr = 0;
        #1;
        total++;
        if (rd0_busy !== !ZERO_REG || any_busy !== !ZERO_REG) begin
            bad++; $display("[TB] FAIL flush_reserve_wins got=%b%b exp=%b%b", rd0_busy, any_busy, !ZERO_REG, !ZERO_REG);
        end
    endtask

    task automatic test_async_reset();
        rsv_en = 1; rsv_addr = 2; wr_en = 1; wr_addr = 1; wr_data = 9'h111;
        tick();
        idle_inputs();
        wr_en = 1; wr_addr = 3; wr_data = 9'h1EE; rd0_addr = 3; rd1_addr = 2;
        #2;
        rst_n = 0;
        model_reset();
        #1;
        total++;
        if (rd0_data !== 9'h000 || rd1_data !== 9'h000) begin
            bad++; $display("[TB] FAIL async_data got=%h/%h exp=000/000", rd0_data, rd1_data);
        end
        total++;
        if ({rd0_busy, rd1_busy, any_busy} !== 3'b000) begin
            bad++; $display("[TB] FAIL async_busy got=%b exp=000", {rd0_busy, rd1_busy, any_busy});
        end
        @(negedge clk);
        rst_n = 1;
        idle_inputs();
        wr_en = 1; wr_addr = 2; wr_data = 9'h0AB;
        tick();
        idle_inputs();
        rd0_addr = 2; rd1_addr = 1;
        #1;
        total++;
        if (rd0_data !== 9'h0AB || rd1_data !== 9'h000) begin
            bad++; $display("[TB] FAIL async_first_write got=%h/%h exp=0ab/000", rd0_data, rd1_data);
        end
    endtask

    task automatic test_zero_reg();
        logic [DW-1:0] expD;
        expD = ZERO_REG ? 9'h000 : 9'h1FF;
        wr_en = 1; wr_addr = 0; wr_data = 9'h1FF; rsv_en = 1; rsv_addr = 0; rd0_addr = 0;
        @(negedge clk);
        total++;
        if (rd0_data !== expD) begin bad++; $display("[TB] FAIL zero_bypass got=%h exp=%h", rd0_data, expD); end
        tick();
        idle_inputs();
        #1;
        total++;
        if (rd0_data !== expD) begin bad++; $display("[TB] FAIL zero_read got=%h exp=%h", rd0_data, expD); end
        total++;
        if (rd0_busy !== !ZERO_REG) begin bad++; $display("[TB] FAIL zero_busy got=%b exp=%b", rd0_busy, !ZERO_REG); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_addr  = AW'($urandom_range(0, DEPTH - 1));
            wr_data  = DW'($urandom);
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_addr = AW'($urandom_range(0, DEPTH - 1));
            sb_flush = ($urandom_range(0, 9) == 0);
            rd0_addr = AW'($urandom_range(0, DEPTH - 1));
            rd1_addr = AW'($urandom_range(0, DEPTH - 1));
            @(negedge clk);
            total++;
            if (rd0_data !== exp_data(rd0_addr) || rd1_data !== exp_data(rd1_addr)) begin
                bad++;
                $display("[TB] FAIL rand_data n=%0d got=%h/%h exp=%h/%h", n, rd0_data, rd1_data,
                         exp_data(rd0_addr), exp_data(rd1_addr));
            end
            total++;
            if (rd0_busy !== exp_busy(rd0_addr) || rd1_busy !== exp_busy(rd1_addr) || any_busy !== exp_any()) begin
                bad++;
                $display("[TB] FAIL rand_busy n=%0d got=%b%b%b exp=%b%b%b", n, rd0_busy, rd1_busy, any_busy,
                         exp_busy(rd0_addr), exp_busy(rd1_addr), exp_any());
            end
            tick();
        end
        idle_inputs();
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        rst_n = 0;
        idle_inputs();
        rd0_addr = 0; rd1_addr = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_flush();
        test_async_reset();
        test_zero_reg();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
